// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared types for the multiply issue path
package sys_defs;

    localparam int SYS_XLEN  = 32;
    localparam int SYS_TAG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLT    = 4'd2,
        ALU_SLTU   = 4'd3,
        ALU_AND    = 4'd4,
        ALU_OR     = 4'd5,
        ALU_XOR    = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_MUL    = 4'd10,
        ALU_MULH   = 4'd11,
        ALU_MULHSU = 4'd12,
        ALU_MULHU  = 4'd13
    } ALU_FUNC;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } MIC_STATE;

    typedef struct packed {
        logic [SYS_XLEN-1:0]  opa;
        logic [SYS_XLEN-1:0]  opb;
        ALU_FUNC              func;
        logic [SYS_TAG_W-1:0] tag;
    } MULT_REQ;

endpackage

// File: rtl/mult_req_fifo.sv
// rtl/mult_req_fifo.sv - in-order request buffer, two write ports and one pop
module mult_req_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_flush,
    input  logic [1:0]          i_wr_en,
    input  logic [1:0][W-1:0]   i_wr_data,
    input  logic                i_pop,
    output logic [CW-1:0]       o_count,
    output logic [W-1:0]        o_head
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_wptr1;
    logic [CW-1:0] w_nwr;

    assign w_wptr1 = r_wptr + PW'(1);
    assign w_nwr   = CW'(i_wr_en[0]) + CW'(i_wr_en[1]);

    // Lane 0 is older, so it takes the first free slot when both lanes write.
    always_ff @(posedge clock) begin
        if (i_wr_en[0]) r_mem[r_wptr] <= i_wr_data[0];
        if (i_wr_en[1]) r_mem[i_wr_en[0] ? w_wptr1 : r_wptr] <= i_wr_data[1];
    end

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_nwr);
            if (i_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + w_nwr - CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - sequences buffered multiply requests through the shared mlu
module mult_issue_ctrl
    import sys_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   refresh,
    input  logic [1:0]             req_valid,
    input  logic [1:0][XLEN-1:0]   req_opa,
    input  logic [1:0][XLEN-1:0]   req_opb,
    input  ALU_FUNC [1:0]          req_func,
    input  logic [1:0][TAG_W-1:0]  req_tag,
    output logic                   req_ready,
    output logic                   mlu_start,
    output logic [XLEN-1:0]        mlu_opa,
    output logic [XLEN-1:0]        mlu_opb,
    output ALU_FUNC                mlu_func,
    output logic                   mlu_refresh,
    input  logic                   mlu_valid,
    input  logic [XLEN-1:0]        mlu_result,
    output logic                   cmp_valid,
    output logic [TAG_W-1:0]       cmp_tag,
    output logic [XLEN-1:0]        cmp_result,
    input  logic                   cmp_ready
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int REQ_W = 2 * XLEN + $bits(ALU_FUNC) + TAG_W;

    typedef struct packed {
        logic [XLEN-1:0]  opa;
        logic [XLEN-1:0]  opb;
        ALU_FUNC          func;
        logic [TAG_W-1:0] tag;
    } mult_req_t;

    MIC_STATE              r_state;
    MIC_STATE              w_next_state;
    logic                  r_start_q;
    logic [XLEN-1:0]       r_opa;
    logic [XLEN-1:0]       r_opb;
    ALU_FUNC               r_func;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_cmp_valid;
    logic [TAG_W-1:0]      r_cmp_tag;
    logic [XLEN-1:0]       r_cmp_result;

    logic [CW-1:0]         w_count;
    mult_req_t             w_head;
    logic [1:0][REQ_W-1:0] w_wr_data;
    logic [1:0]            w_accept;
    logic                  w_issue;
    logic                  w_capture;

    assign req_ready = (w_count <= CW'(DEPTH - 2)) && !refresh;
    assign w_accept  = req_valid & {2{req_ready}};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_wr_data[i] = {req_opa[i], req_opb[i], req_func[i], req_tag[i]};
        end
    end

    mult_req_fifo #(
        .W     (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_flush   (refresh),
        .i_wr_en   (w_accept),
        .i_wr_data (w_wr_data),
        .i_pop     (w_issue),
        .o_count   (w_count),
        .o_head    (w_head)
    );

    // Issue only when the completion register is empty or draining, so a capture never blocks.
    assign w_issue   = (r_state == S_IDLE) && (w_count != '0) &&
                       (!r_cmp_valid || cmp_ready) && !refresh;
    assign w_capture = (r_state == S_BUSY) && mlu_valid && !r_start_q && !refresh;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_issue)   w_next_state = S_BUSY;
            S_BUSY:  if (w_capture) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (refresh) w_next_state = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clock) begin
        if (reset || refresh) r_start_q <= 1'b0;
        else                  r_start_q <= w_issue;
    end

    // Operands and func stay put until the next issue; mlu decodes its result from func.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_opa  <= '0;
            r_opb  <= '0;
            r_func <= ALU_FUNC'(4'd0);
            r_tag  <= '0;
        end else if (w_issue) begin
            r_opa  <= w_head.opa;
            r_opb  <= w_head.opb;
            r_func <= w_head.func;
            r_tag  <= w_head.tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmp_valid  <= 1'b0;
            r_cmp_tag    <= '0;
            r_cmp_result <= '0;
        end else if (refresh) begin
            r_cmp_valid  <= 1'b0;
        end else if (w_capture) begin
            r_cmp_valid  <= 1'b1;
            r_cmp_tag    <= r_tag;
            r_cmp_result <= mlu_result;
        end else if (cmp_ready) begin
            r_cmp_valid  <= 1'b0;
        end
    end

    assign mlu_start   = r_start_q;
    assign mlu_opa     = r_opa;
    assign mlu_opb     = r_opb;
    assign mlu_func    = r_func;
    assign mlu_refresh = refresh;
    assign cmp_valid   = r_cmp_valid;
    assign cmp_tag     = r_cmp_tag;
    assign cmp_result  = r_cmp_result;

endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Issue controller for the shared multiply unit (`mlu`). It accepts multiply requests from both superscalar issue lanes into a small in-order buffer, sequences them one at a time through the multi-cycle `mlu`, and holds operands and function stable for the full operation. It returns each product with its ROB tag on a valid/ready completion port toward CDB arbitration. It also propagates squash (`refresh`) to the multiplier.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `TAG_W`, 5, ROB tag width
- `DEPTH`, 4, request buffer entries (power of 2, ≥2)

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `refresh`  in  1  pipeline squash
- `req_valid`  in  2  per-lane request; lane 0 is older
- `req_opa`, `req_opb`  in  2×XLEN  operands per lane
- `req_func`  in  2×ALU_FUNC  MUL/MULH/MULHSU/MULHU per lane
- `req_tag`  in  2×TAG_W  ROB tag per lane
- `req_ready`  out  1  free entries ≥ 2 and !refresh
- `mlu_start`  out  1  one-cycle start pulse (drives `mlu` val_valid)
- `mlu_opa`, `mlu_opb`  out  XLEN  held operands
- `mlu_func`  out  ALU_FUNC  held function
- `mlu_refresh`  out  1  equals `refresh`, combinational
- `mlu_valid`  in  1  multiplier done
- `mlu_result`  in  XLEN  multiplier result
- `cmp_valid`  out  1  completion valid
- `cmp_tag`  out  TAG_W  completion tag
- `cmp_result`  out  XLEN  completion data
- `cmp_ready`  in  1  CDB accepts completion

## Operation
- **Enqueue:** lane i is accepted when `req_valid[i] && req_ready`. If both lanes are accepted in one cycle, lane 0 is written first. The pointers wrap modulo DEPTH. The count is a `$clog2(DEPTH)+1`-bit register.
- **FSM states:**
  - S_IDLE → S_BUSY when the buffer is non-empty and (`!cmp_valid || cmp_ready`). At that edge: pop the head, load `mlu_opa`/`mlu_opb`/`mlu_func`/tag registers, and set `start_q`.
  - S_BUSY → S_IDLE on `mlu_valid && !mlu_start`. At that edge: `cmp_result` ← `mlu_result`, `cmp_tag` ← held tag, `cmp_valid` ← 1.
- **Start and hold rules:**
  - `mlu_start` = `start_q`, which is high only in the first S_BUSY cycle.
  - `mlu_opa`, `mlu_opb` and `mlu_func` are stable from the start cycle through the done cycle inclusive, because `mlu` decodes its result combinationally from func.
- **Completion register:**
  - `cmp_valid` clears on `cmp_valid && cmp_ready` unless it is reloaded in the same edge.
  - An issue is only allowed when the completion register is empty or draining, so a capture can never be blocked.
- **Refresh:**
  - Flush the buffer (pointers and count to 0), go to S_IDLE, and clear `start_q` and `cmp_valid`.
  - Same-cycle requests are not accepted, because `req_ready` is low.
  - `mlu_valid` is ignored in that cycle.
  - Refresh overrides a simultaneous capture or issue.
- **Reset:** same effect as refresh, and additionally all held registers go to 0.
- `mlu_valid` is ignored in S_IDLE.

## Timing
- **Reset values:**
  - `req_ready` = 1 (for DEPTH ≥ 2).
  - All other outputs = 0, including `mlu_start`, `mlu_opa`, `mlu_opb`, `mlu_func` (encoding 0), `cmp_valid`, `cmp_tag`, `cmp_result`.
  - `mlu_refresh` mirrors `refresh`.
- **Latency:**
  - Request accepted at the end of cycle N, into an empty buffer in S_IDLE with an empty completion register.
  - Issue edge at the end of N+1; `mlu_start` is high in N+2.
  - Done in cycle D gives `cmp_valid` in D+1.
  - If `cmp_ready` is high in D+1, the next op issues at the end of D+1 and its `mlu_start` is in D+2.
- At most one multiply is in flight. Ordering is strictly FIFO.
- `req_ready` is registered-count based and does not depend on same-cycle pops.

## Structure
- Shared package (sys_defs):
  - `MULT_REQ` packed struct {opa, opb, func, tag}.
  - `MIC_STATE` enum {S_IDLE, S_BUSY}.
  - `ALU_FUNC` already lives there.
- Sub-module `mult_req_fifo`:
  - Parameterized DEPTH, two write ports, one pop.
  - Exposes count and head; flushes on reset or refresh.
- Top level: FSM, held-operand registers, completion register.

## Test plan
Test-plan scenarios:
- **Single request:** reset, then one lane-0 request MUL 7×6, tag 3. The `mlu` model pulses done 8 cycles after start. Required: `mlu_start` 2 cycles after accept; `cmp_valid` one cycle after done with result 42, tag 3; `mlu_func` stable throughout.
- **Dual-lane ordering:** both lanes in the same cycle, lane 0 MULH tag 1 and lane 1 MULHU tag 2, with `cmp_ready` = 1. Required: completions in order tag 1 then tag 2; second `mlu_start` one cycle after the first `cmp_valid`.
- **Buffer fill:** hold `cmp_ready` = 0 and push 5 requests. Required: `req_ready` drops once count > DEPTH−2; no second `mlu_start` while `cmp_valid` is stalled; wrap-around order preserved after draining.
- **Mid-operation refresh:** refresh 3 cycles after `mlu_start` with 2 entries queued. Required: `mlu_refresh` high the same cycle; a late `mlu_valid` is ignored; `cmp_valid` stays 0; buffer empty; the next request issues normally.
- **Refresh on capture edge:** refresh coincides with `mlu_valid`. Required: no completion, state S_IDLE.
- **Mid-operation reset:** reset asserted in S_BUSY. Required: all outputs 0 on the next cycle and `req_ready` = 1.
